// File: rtl/mux_select_ctrl.sv
// Select controller for a 2:1 data mux: arbitrates between sources A and B,
// enforces a minimum ownership dwell and a one-cycle blanking gap on every select change.
module mux_select_ctrl #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             select,
  output logic             grant_a,
  output logic             grant_b,
  output logic             valid,
  output logic [CNT_W-1:0] switch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             select_q, select_d;
  logic             target_q, target_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] switch_count_q, switch_count_d;
  logic             grant_a_q, grant_a_d;
  logic             grant_b_q, grant_b_d;
  logic             valid_q, valid_d;

  logic             toggle_s;
  logic             winner_s;
  logic [CNT_W-1:0] dwell_inc_s;

  // Next-state, select, dwell and counter logic.
  always_comb begin
    state_d        = state_q;
    select_d       = select_q;
    target_d       = target_q;
    last_owner_d   = last_owner_q;
    dwell_d        = dwell_q;
    toggle_s       = 1'b0;
    winner_s       = 1'b0;
    // dwell_inc_s counts grant cycles including the current one.
    dwell_inc_s    = (dwell_q >= DWELL_MAX) ? DWELL_MAX : (dwell_q + CNT_ONE);

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          winner_s = (req_a && req_b) ? ~last_owner_q : req_b;
          if (winner_s == select_q) begin
            state_d      = winner_s ? OWN_B : OWN_A;
            dwell_d      = CNT_ZERO;
            last_owner_d = winner_s;
          end else begin
            toggle_s = 1'b1;
            target_d = winner_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OWN_A: begin
        dwell_d = dwell_inc_s;
        if (!req_a && req_b) begin
          toggle_s = 1'b1;
          target_d = 1'b1;
        end else if (!req_a) begin
          state_d = IDLE;
        end else if (req_b && (dwell_inc_s == DWELL_MAX)) begin
          toggle_s = 1'b1;
          target_d = 1'b1;
        end else begin
          state_d = OWN_A;
        end
      end
      OWN_B: begin
        dwell_d = dwell_inc_s;
        if (!req_b && req_a) begin
          toggle_s = 1'b1;
          target_d = 1'b0;
        end else if (!req_b) begin
          state_d = IDLE;
        end else if (req_a && (dwell_inc_s == DWELL_MAX)) begin
          toggle_s = 1'b1;
          target_d = 1'b0;
        end else begin
          state_d = OWN_B;
        end
      end
      BLANK: begin
        // Target was latched on entry; requests are ignored here.
        state_d      = target_q ? OWN_B : OWN_A;
        dwell_d      = CNT_ZERO;
        last_owner_d = target_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (toggle_s) begin
      state_d  = BLANK;
      select_d = ~select_q;
    end else begin
      select_d = select_d;
    end

    if (toggle_s && (switch_count_q != CNT_FULL)) begin
      switch_count_d = switch_count_q + CNT_ONE;
    end else begin
      switch_count_d = switch_count_q;
    end

    grant_a_d = (state_d == OWN_A);
    grant_b_d = (state_d == OWN_B);
    valid_d   = grant_a_d | grant_b_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      select_q       <= 1'b0;
      target_q       <= 1'b0;
      last_owner_q   <= 1'b1;
      dwell_q        <= CNT_ZERO;
      switch_count_q <= CNT_ZERO;
      grant_a_q      <= 1'b0;
      grant_b_q      <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      select_q       <= select_d;
      target_q       <= target_d;
      last_owner_q   <= last_owner_d;
      dwell_q        <= dwell_d;
      switch_count_q <= switch_count_d;
      grant_a_q      <= grant_a_d;
      grant_b_q      <= grant_b_d;
      valid_q        <= valid_d;
    end
  end

  assign select       = select_q;
  assign grant_a      = grant_a_q;
  assign grant_b      = grant_b_q;
  assign valid        = valid_q;
  assign switch_count = switch_count_q;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Scoreboard bench for mux_select_ctrl: a default instance (DWELL 4, CNT_W 8)
// and a saturation instance (DWELL 1, CNT_W 3).
module tb_mux_select_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic       select, grant_a, grant_b, valid;
  logic [7:0] switch_count;
  logic       s_req_a, s_req_b;
  logic       s_select, s_grant_a, s_grant_b, s_valid;
  logic [2:0] s_switch_count;

  typedef struct packed {
    logic       which;
    logic       sel;
    logic       ga;
    logic       gb;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  mux_select_ctrl #(.DWELL_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .select(select), .grant_a(grant_a), .grant_b(grant_b),
    .valid(valid), .switch_count(switch_count)
  );

  mux_select_ctrl #(.DWELL_CYCLES(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_a(s_req_a), .req_b(s_req_b),
    .select(s_select), .grant_a(s_grant_a), .grant_b(s_grant_b),
    .valid(s_valid), .switch_count(s_switch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic ra, input logic rb,
                      input logic sel, input logic ga, input logic gb,
                      input logic [7:0] cnt);
    exp_t e;
    if (!w) begin
      req_a = ra;
      req_b = rb;
    end else begin
      s_req_a = ra;
      s_req_b = rb;
    end
    e = '{which: w, sel: sel, ga: ga, gb: gb, cnt: cnt};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry per clock, compared 2 time units after the edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!e.which) begin
        check("select",  {31'd0, select},  {31'd0, e.sel});
        check("grant_a", {31'd0, grant_a}, {31'd0, e.ga});
        check("grant_b", {31'd0, grant_b}, {31'd0, e.gb});
        check("valid",   {31'd0, valid},   {31'd0, e.ga | e.gb});
        check("switch_count", {24'd0, switch_count}, {24'd0, e.cnt});
        check("no_overlap", {31'd0, grant_a & grant_b}, 32'd0);
      end else begin
        check("sat_select",  {31'd0, s_select},  {31'd0, e.sel});
        check("sat_grant_a", {31'd0, s_grant_a}, {31'd0, e.ga});
        check("sat_grant_b", {31'd0, s_grant_b}, {31'd0, e.gb});
        check("sat_valid",   {31'd0, s_valid},   {31'd0, e.ga | e.gb});
        check("sat_switch_count", {29'd0, s_switch_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    int m, ph, t;
    logic o;
    rst_n   = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    s_req_a = 1'b0;
    s_req_b = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("reset_select", {31'd0, select}, 32'd0);
    check("reset_valid",  {31'd0, valid},  32'd0);
    check("reset_count",  {24'd0, switch_count}, 32'd0);

    // Single source B from IDLE with select=0: blank, then grant, then release.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);

    // Early release: A owns 2 cycles with B waiting, then drops.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);

    // Return to A at select=0, then a one-cycle B pulse (blank-target drop).
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);

    // B owns directly (select already 1), then reset mid-OWN_B.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_select",  {31'd0, select},  32'd0);
    check("async_rst_grant_b", {31'd0, grant_b}, 32'd0);
    check("async_rst_valid",   {31'd0, valid},   32'd0);
    check("async_rst_count",   {24'd0, switch_count}, 32'd0);
    req_a = 1'b1;
    req_b = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Both requesting for 30 edges: 4 grant cycles, 1 blank, alternating from A.
    for (int k = 1; k <= 30; k++) begin
      m  = (k - 1) / 5;
      ph = (k - 1) % 5;
      o  = ((m % 2) == 1);
      if (ph < 4) step(1'b0, 1'b1, 1'b1, o, ~o, o, 8'(m));
      else        step(1'b0, 1'b1, 1'b1, ~o, 1'b0, 1'b0, 8'(m + 1));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);

    // DWELL 1 alternation and 3-bit counter saturation at 7.
    for (int k = 1; k <= 22; k++) begin
      t = k / 2;
      o = ((t % 2) == 1);
      if ((k % 2) == 1) step(1'b1, 1'b1, 1'b1, o, ~o, o, 8'((t > 7) ? 7 : t));
      else              step(1'b1, 1'b1, 1'b1, o, 1'b0, 1'b0, 8'((t > 7) ? 7 : t));
    end
    s_req_a = 1'b0;
    s_req_b = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_select_ctrl.md
# mux_select_ctrl

Upstream select controller for the 2:1 data mux (`a`, `b`, `select`, `y`). It arbitrates between two requesting sources, A (mux input `a`) and B (mux input `b`), and drives the mux `select` line. It guarantees a minimum ownership dwell and a one-cycle blanking gap on every select change, so that downstream logic only samples `y` while `valid` is high.

## Interface
- `DWELL_CYCLES`, default 4: minimum number of grant cycles an owner keeps while it still requests and the other side is waiting. Legal range 1..255.
- `CNT_W`, default 8: width of the dwell counter and of `switch_count`.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_a` input 1: source A requests the mux.
- `req_b` input 1: source B requests the mux.
- `select` output 1: drives the mux `select`. 0 selects `a`, 1 selects `b`.
- `grant_a` output 1: A owns the mux this cycle.
- `grant_b` output 1: B owns the mux this cycle.
- `valid` output 1: the mux output `y` is stable and belongs to the granted source.
- `switch_count` output CNT_W: number of `select` toggles since reset, saturating at 2^CNT_W-1.

## Operation
- All outputs are registered.
- FSM states:
  - IDLE: no grant, `select` holds its last value.
  - OWN_A: `grant_a`=1, `valid`=1, `select`=0.
  - OWN_B: `grant_b`=1, `valid`=1, `select`=1.
  - BLANK: grants=0, `valid`=0. Lasts exactly 1 cycle after a `select` toggle, then enters OWN of the new owner.
- Reset (asynchronous, takes effect immediately at any state): state=IDLE, `select`=0, `grant_a`=`grant_b`=0, `valid`=0, `switch_count`=0, dwell counter=0, `last_owner`=B (so A wins the first tie).
- IDLE transitions:
  - Winner is the sole requester. If both request, the winner is the side that is not `last_owner`.
  - If the winner already matches `select`: go directly to OWN_winner.
  - Otherwise: toggle `select`, go to BLANK, then OWN_winner.
  - No request: stay in IDLE.
- OWN_x:
  - The dwell counter clears on entry and increments each cycle, saturating at DWELL_CYCLES.
  - `req_x` low with the other side requesting: toggle `select`, go to BLANK.
  - `req_x` low with no other request: go to IDLE, `select` unchanged.
  - `req_x` high, other side requesting, dwell counter = DWELL_CYCLES: preempt. Toggle `select`, go to BLANK.
  - Otherwise: stay in OWN_x.
- `last_owner` updates to x on entry to OWN_x.
- BLANK ignores request changes. The target owner is fixed at entry. If the target has dropped its request by the end of BLANK, the FSM still enters OWN_target for 1 cycle, then applies the OWN exit rules.
- `switch_count` increments on every `select` toggle and holds at all-ones.
- `grant_a` and `grant_b` are never high together. `valid` = `grant_a` | `grant_b`.

## Timing
- Request latency with no switch: request sampled at edge N, grant and `valid` high after edge N.
- Request latency with a switch: `select` toggles at edge N, BLANK occupies cycle N..N+1, grant rises at edge N+1.
- Release: `req_x` sampled low at edge N, grant falls at edge N.
- Both requesting continuously, DWELL_CYCLES=4: the pattern repeats as 4 cycles OWN_A, 1 BLANK, 4 cycles OWN_B, 1 BLANK.
- DWELL_CYCLES=1: the owner yields after 1 grant cycle whenever the other side waits.
- Reset mid-BLANK or mid-OWN: all outputs clear asynchronously. The first post-reset arbitration favours A.
- Requests must be synchronous to `clk`. No internal synchroniser.

## Test plan
- Reset: assert `rst_n`=0 mid-OWN_B. Required: immediately `select`=0, grants=0, `valid`=0, `switch_count`=0. Release reset with `req_a`=`req_b`=1 → `grant_a`=1 one cycle later, no BLANK.
- Single source: `req_b`=1 from IDLE with `select`=0 → `select`=1 next edge, `valid`=0 for 1 cycle, then `grant_b`=1; `switch_count`=1. Drop `req_b` → `grant_b`=0 next edge, `select` stays 1.
- Fairness, DWELL_CYCLES=4: both requests held 30 cycles → strict alternation of 4 grant cycles and 1 blank; `switch_count`=6 at the end; no overlapping grants.
- Early release: A owns, B waiting, `req_a` drops after 2 grant cycles → BLANK next edge, then `grant_b`.
- Saturation: CNT_W=3, force 10 switches → `switch_count` holds at 7.
- Blank-target drop: `req_b` pulses for 1 cycle while A idles at `select`=0 → BLANK, 1 cycle of `grant_b`, then IDLE with `select`=1.
